// File: rtl/cram_cfg_loader.sv
// CRAM chain master: LOAD serialises wr_data words into the chain; READ rotates the chain once and returns its bits as words.
// Latency: a word's MSB reaches cfg_data one cycle after its handshake. A full capture register with rd_valid unaccepted stalls the chain.
module cram_cfg_loader #(
  parameter int CHAIN_LEN = 320,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              rb_mode,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              cfg_data,
  output logic              cfg_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done
);

  localparam int MAXV = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] WLEN   = CW'(WORD_W);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt, acc_cnt, sh_cnt, cap_cnt;
  logic [CW-1:0]     rem, nbits;
  logic [WORD_W-1:0] shreg, cap;
  logic              ld_en_q, ld_dat_q;
  logic              wr_hs, cap_full, rd_stall, xfer;

  always_comb begin
    rem      = LEN - acc_cnt;
    nbits    = (rem >= WLEN) ? WLEN : rem;
    wr_ready = (state_q == S_LOAD) && (sh_cnt == '0) && (acc_cnt < LEN);
    wr_hs    = wr_ready && wr_valid;
    // Final partial word counts as full once the last chain bit is captured.
    cap_full = (cap_cnt == WLEN) || ((bit_cnt == LEN) && (cap_cnt != '0));
    rd_stall = cap_full && rd_valid && !rd_ready;
    xfer     = (state_q == S_READ) && cap_full && !rd_stall;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    case (state_q)
      S_LOAD: begin
        cfg_en   = ld_en_q;
        cfg_data = ld_dat_q;
      end
      S_READ: begin
        cfg_en   = (bit_cnt < LEN) && !rd_stall;
        cfg_data = chain_tail;
      end
      default: ;
    endcase
    busy    = (state_q == S_LOAD) || (state_q == S_READ);
    done    = (state_q == S_FIN);
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = rb_mode ? S_READ : S_LOAD;
      S_LOAD: if (ld_en_q && (bit_cnt == LEN_M1)) state_d = S_FIN;
      S_READ: if ((bit_cnt == LEN) && (cap_cnt == '0) && (!rd_valid || rd_ready)) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt  <= '0;
      acc_cnt  <= '0;
      sh_cnt   <= '0;
      cap_cnt  <= '0;
      shreg    <= '0;
      cap      <= '0;
      ld_en_q  <= 1'b0;
      ld_dat_q <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt  <= '0;
          acc_cnt  <= '0;
          sh_cnt   <= '0;
          cap_cnt  <= '0;
          ld_en_q  <= 1'b0;
          rd_valid <= 1'b0;
        end
        S_LOAD: begin
          if (ld_en_q) bit_cnt <= bit_cnt + ONE;
          if (sh_cnt != '0) begin
            ld_dat_q <= shreg[WORD_W-1];
            shreg    <= shreg << 1;
            sh_cnt   <= sh_cnt - ONE;
            ld_en_q  <= 1'b1;
          end else if (wr_hs) begin
            // Bits beyond the chain length in the last word are never counted in.
            ld_dat_q <= wr_data[WORD_W-1];
            shreg    <= wr_data << 1;
            sh_cnt   <= nbits - ONE;
            acc_cnt  <= acc_cnt + nbits;
            ld_en_q  <= 1'b1;
          end else begin
            ld_en_q  <= 1'b0;
          end
        end
        S_READ: begin
          if (cfg_en) bit_cnt <= bit_cnt + ONE;
          if (xfer) begin
            rd_data  <= cap << (WLEN - cap_cnt);
            rd_valid <= 1'b1;
            cap      <= cfg_en ? WORD_W'(chain_tail) : '0;
            cap_cnt  <= cfg_en ? ONE : '0;
          end else begin
            if (rd_ready) rd_valid <= 1'b0;
            if (cfg_en) begin
              cap     <= (cap << 1) | WORD_W'(chain_tail);
              cap_cnt <= cap_cnt + ONE;
            end
          end
        end
        default: begin
          ld_en_q  <= 1'b0;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
